// File: rtl/one_to_8_demux.sv
// One-to-eight demultiplexer: routes a DATA_W-bit input onto one of eight lanes
// selected by sel, with either registered or purely combinational outputs.
module one_to_8_demux #(
    parameter int DATA_W     = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   a,
    input  logic [2:0]          sel,
    output logic [8*DATA_W-1:0] out,
    output logic                out_valid
);

    logic [8*DATA_W-1:0] route;

    // NOTE: assign a default before any conditional write in always_comb so no latch is inferred.
    always_comb begin
        route = '0;
        route[sel*DATA_W +: DATA_W] = a;
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [8*DATA_W-1:0] out_q;
            logic                valid_q;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q   <= '0;
                    valid_q <= 1'b0;
                end else if (en) begin
                    out_q   <= route;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign out       = out_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            // clk is intentionally unused here; rst still forces the outputs low.
            logic unused_clk;
            assign unused_clk = clk;

            always_comb begin
                out       = '0;
                out_valid = 1'b0;
                if (en && !rst) begin
                    out       = route;
                    out_valid = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_one_to_8_demux.sv
// Scoreboard bench for one_to_8_demux: registered instance checked by a monitor
// against queued expectations, combinational instances checked inline.
module tb_one_to_8_demux;

    typedef struct packed {
        logic [7:0] out;
        logic       valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [0:0]  a   = '0;
    logic [2:0]  sel = '0;
    logic [7:0]  r_out;
    logic        r_valid;

    logic        c_rst = 1'b0;
    logic        c_en  = 1'b0;
    logic [0:0]  c_a   = '0;
    logic [2:0]  c_sel = '0;
    logic [7:0]  c_out;
    logic        c_valid;

    logic [3:0]  w_a = '0;
    logic [31:0] w_out;
    logic        w_valid;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    one_to_8_demux #(.DATA_W(1), .REGISTERED(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .en(en), .a(a), .sel(sel),
        .out(r_out), .out_valid(r_valid)
    );

    one_to_8_demux #(.DATA_W(1), .REGISTERED(1'b0)) dut_comb (
        .clk(clk), .rst(c_rst), .en(c_en), .a(c_a), .sel(c_sel),
        .out(c_out), .out_valid(c_valid)
    );

    one_to_8_demux #(.DATA_W(4), .REGISTERED(1'b0)) dut_w4 (
        .clk(clk), .rst(c_rst), .en(c_en), .a(w_a), .sel(c_sel),
        .out(w_out), .out_valid(w_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one registered-mode cycle; sel wiggles before settling to prove only the edge value counts.
    task automatic cycle(input logic e, input logic av, input logic [2:0] s,
                         input logic [7:0] exp_out, input logic exp_valid);
        exp_t x;
        @(negedge clk);
        en  = e;
        a   = av;
        sel = ~s;
        #1 sel = s;
        x.out   = exp_out;
        x.valid = exp_valid;
        sb_q.push_back(x);
    endtask

    task automatic comb(input string name, input logic e, input logic av, input logic [2:0] s,
                        input logic [7:0] exp_out, input logic exp_valid);
        c_en  = e;
        c_a   = av;
        c_sel = s;
        #1;
        check({name, "_out"}, {24'd0, c_out}, {24'd0, exp_out});
        check({name, "_valid"}, {31'd0, c_valid}, {31'd0, exp_valid});
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("sb_out", {24'd0, r_out}, {24'd0, x.out});
                check("sb_valid", {31'd0, r_valid}, {31'd0, x.valid});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset is asynchronous and clock edges are ignored while it is held.
        en = 1'b1; a = 1'b1; sel = 3'd3;
        #1 rst = 1'b1;
        #1;
        check("rst_out", {24'd0, r_out}, 32'd0);
        check("rst_valid", {31'd0, r_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out", {24'd0, r_out}, 32'd0);
        check("rst_hold_valid", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 1'b1, 3'b001, 8'b0000_0010, 1'b1);
        cycle(1'b1, 1'b0, 3'b000, 8'b0000_0000, 1'b1);
        cycle(1'b1, 1'b1, 3'b000, 8'b0000_0001, 1'b1);
        cycle(1'b1, 1'b1, 3'b011, 8'b0000_1000, 1'b1);
        cycle(1'b1, 1'b1, 3'b100, 8'b0001_0000, 1'b1);
        cycle(1'b1, 1'b1, 3'b110, 8'b0100_0000, 1'b1);
        cycle(1'b1, 1'b0, 3'b010, 8'b0000_0000, 1'b1);
        cycle(1'b1, 1'b0, 3'b101, 8'b0000_0000, 1'b1);
        cycle(1'b1, 1'b1, 3'b111, 8'b1000_0000, 1'b1);
        cycle(1'b0, 1'b1, 3'b000, 8'b1000_0000, 1'b0);
        cycle(1'b0, 1'b0, 3'b011, 8'b1000_0000, 1'b0);
        cycle(1'b1, 1'b1, 3'b010, 8'b0000_0100, 1'b1);
        cycle(1'b1, 1'b1, 3'b101, 8'b0010_0000, 1'b1);

        // Pulse reset between edges while lane 5 is held.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out", {24'd0, r_out}, 32'd0);
        check("midrst_valid", {31'd0, r_valid}, 32'd0);
        #1 rst = 1'b0;
        cycle(1'b1, 1'b1, 3'b010, 8'b0000_0100, 1'b1);
        cycle(1'b1, 1'b1, 3'b110, 8'b0100_0000, 1'b1);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        // Combinational instance: zero latency, en=0 and rst force zeros.
        comb("c_s3", 1'b1, 1'b1, 3'b011, 8'b0000_1000, 1'b1);
        comb("c_s4", 1'b1, 1'b1, 3'b100, 8'b0001_0000, 1'b1);
        comb("c_s6", 1'b1, 1'b1, 3'b110, 8'b0100_0000, 1'b1);
        comb("c_a0s2", 1'b1, 1'b0, 3'b010, 8'b0000_0000, 1'b1);
        comb("c_a0s5", 1'b1, 1'b0, 3'b101, 8'b0000_0000, 1'b1);
        comb("c_en0", 1'b0, 1'b1, 3'b011, 8'b0000_0000, 1'b0);
        c_rst = 1'b1;
        comb("c_rst", 1'b1, 1'b1, 3'b111, 8'b0000_0000, 1'b0);
        c_rst = 1'b0;
        comb("c_s7", 1'b1, 1'b1, 3'b111, 8'b1000_0000, 1'b1);

        // Wide lanes land at sel*DATA_W.
        w_a = 4'hA;
        c_en = 1'b1; c_sel = 3'd5; #1;
        check("w4_s5", w_out, 32'h00A0_0000);
        c_sel = 3'd0; #1;
        check("w4_s0", w_out, 32'h0000_000A);
        c_sel = 3'd7; #1;
        check("w4_s7", w_out, 32'hA000_0000);
        check("w4_valid", {31'd0, w_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
